// File: rtl/msix_irq_scheduler.sv
// msix_irq_scheduler: captures TX/RX MSI-X vector requests into a pending bitmap, picks eligible
// vectors round-robin, looks each up in the MSI-X table and issues one DMA write per interrupt.
// Optional delivery/coalescing counters are enabled by defining MSIX_IRQ_STATS_EN.
`ifndef MSI_NUM_WIDTH
`define MSI_NUM_WIDTH 11
`endif
`ifndef IRQ_MSG
`define IRQ_MSG 32
`endif
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 64
`endif

module msix_irq_scheduler #(
  parameter int INTERRUPTE_NUM = 64,
  localparam int VEC_W = $clog2(INTERRUPTE_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`MSI_NUM_WIDTH-1:0]   tx_irq_req_msix,
  input  logic                        tx_irq_req_valid,
  output logic                        tx_irq_req_ready,
  input  logic [`MSI_NUM_WIDTH-1:0]   rx_irq_req_msix,
  input  logic                        rx_irq_req_valid,
  output logic                        rx_irq_req_ready,
  input  logic [INTERRUPTE_NUM-1:0]   vec_mask,
  input  logic                        func_mask,
  output logic [VEC_W-1:0]            lut_req_msix,
  output logic                        lut_req_valid,
  input  logic                        lut_req_ready,
  input  logic [`IRQ_MSG-1:0]         lut_rsp_msg,
  input  logic [`DMA_ADDR_WIDTH-1:0]  lut_rsp_addr,
  input  logic                        lut_rsp_valid,
  output logic                        lut_rsp_ready,
  output logic [`DMA_ADDR_WIDTH-1:0]  dma_wr_addr,
  output logic [`IRQ_MSG-1:0]         dma_wr_data,
  output logic                        dma_wr_valid,
  input  logic                        dma_wr_ready,
  output logic [INTERRUPTE_NUM-1:0]   pending,
  output logic                        irq_drop,
  output logic [1:0]                  dbg_state,
  output logic [VEC_W-1:0]            dbg_rr_ptr
`ifdef MSIX_IRQ_STATS_EN
  ,
  output logic [31:0]                 irq_sent_cnt,
  output logic [31:0]                 irq_coalesced_cnt
`endif
);

  // Handshake rule for every valid/ready pair: a transfer happens on a rising edge where both
  // are 1; the sender holds valid and its payload unchanged until that edge.
  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_RSP, ISSUE} state_t;

  localparam logic [`MSI_NUM_WIDTH-1:0] NUM_VEC = `MSI_NUM_WIDTH'(INTERRUPTE_NUM);

  state_t                      r_state, w_next;
  logic [INTERRUPTE_NUM-1:0]   r_pending, w_set, w_clr, w_elig, w_rot;
  logic [VEC_W-1:0]            r_rr_ptr, r_sel, w_off, w_pick;
  logic                        w_any, w_tx_ok, w_rx_ok, w_bad_req, w_rsp_hs, w_dma_hs;
  logic                        r_lut_req_valid, r_lut_rsp_ready, r_dma_wr_valid, r_irq_drop;
  logic [`DMA_ADDR_WIDTH-1:0]  r_addr;
  logic [`IRQ_MSG-1:0]         r_msg;

  assign tx_irq_req_ready = ~rst;
  assign rx_irq_req_ready = ~rst;

  assign w_tx_ok   = tx_irq_req_msix < NUM_VEC;
  assign w_rx_ok   = rx_irq_req_msix < NUM_VEC;
  assign w_bad_req = (tx_irq_req_valid & ~w_tx_ok) | (rx_irq_req_valid & ~w_rx_ok);

  always_comb begin
    w_set = '0;
    if (tx_irq_req_valid && w_tx_ok) w_set[tx_irq_req_msix[VEC_W-1:0]] = 1'b1;
    if (rx_irq_req_valid && w_rx_ok) w_set[rx_irq_req_msix[VEC_W-1:0]] = 1'b1;
  end

  assign w_elig = func_mask ? '0 : (r_pending & ~vec_mask);
  assign w_any  = |w_elig;

  // Rotate so bit 0 is rr_ptr; the lowest set bit is the offset of the next vector to serve.
  always_comb begin
    w_rot = INTERRUPTE_NUM'({w_elig, w_elig} >> r_rr_ptr);
    w_off = '0;
    for (int i = INTERRUPTE_NUM - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = VEC_W'(i);
    end
  end

  assign w_pick = r_rr_ptr + w_off;

  always_comb begin
    w_clr = '0;
    if (r_state == IDLE && w_any) w_clr[w_pick] = 1'b1;
  end

  assign w_rsp_hs = (r_state == WAIT_RSP) && lut_rsp_valid;
  assign w_dma_hs = (r_state == ISSUE) && dma_wr_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_any) w_next = LOOKUP;
      LOOKUP:   if (lut_req_ready) w_next = WAIT_RSP;
      WAIT_RSP: if (lut_rsp_valid) w_next = (lut_rsp_addr == '0) ? IDLE : ISSUE;
      ISSUE:    if (dma_wr_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_pending       <= '0;
      r_rr_ptr        <= '0;
      r_sel           <= '0;
      r_lut_req_valid <= 1'b0;
      r_lut_rsp_ready <= 1'b0;
      r_dma_wr_valid  <= 1'b0;
      r_irq_drop      <= 1'b0;
      r_addr          <= '0;
      r_msg           <= '0;
    end else begin
      r_state         <= w_next;
      // A new request for the bit being picked survives, so that vector fires again.
      r_pending       <= (r_pending & ~w_clr) | w_set;
      if (r_state == IDLE && w_any) begin
        r_sel    <= w_pick;
        r_rr_ptr <= w_pick + VEC_W'(1);
      end
      r_lut_req_valid <= (w_next == LOOKUP);
      r_lut_rsp_ready <= (w_next == WAIT_RSP);
      r_dma_wr_valid  <= (w_next == ISSUE);
      if (w_rsp_hs) begin
        r_addr <= lut_rsp_addr;
        r_msg  <= lut_rsp_msg;
      end
      r_irq_drop      <= w_bad_req | (w_rsp_hs && lut_rsp_addr == '0);
    end
  end

  assign lut_req_msix  = r_sel;
  assign lut_req_valid = r_lut_req_valid;
  assign lut_rsp_ready = r_lut_rsp_ready;
  assign dma_wr_addr   = r_addr;
  assign dma_wr_data   = r_msg;
  assign dma_wr_valid  = r_dma_wr_valid;
  assign pending       = r_pending;
  assign irq_drop      = r_irq_drop;
  assign dbg_state     = r_state;
  assign dbg_rr_ptr    = r_rr_ptr;

`ifdef MSIX_IRQ_STATS_EN
  logic        w_coal;
  logic [31:0] r_sent_cnt, r_coal_cnt;

  assign w_coal = (tx_irq_req_valid && w_tx_ok && r_pending[tx_irq_req_msix[VEC_W-1:0]]) ||
                  (rx_irq_req_valid && w_rx_ok && r_pending[rx_irq_req_msix[VEC_W-1:0]]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sent_cnt <= '0;
      r_coal_cnt <= '0;
    end else begin
      if (w_dma_hs) r_sent_cnt <= r_sent_cnt + 32'd1;
      if (w_coal)   r_coal_cnt <= r_coal_cnt + 32'd1;
    end
  end

  assign irq_sent_cnt      = r_sent_cnt;
  assign irq_coalesced_cnt = r_coal_cnt;
`else
  logic w_unused;
  assign w_unused = w_dma_hs;
`endif

endmodule

// File: tb/tb_msix_irq_scheduler.sv
// Directed + randomized bench for msix_irq_scheduler; expected DMA writes, drops and counters
// come from a set-based model of the pending vectors and the round-robin service order.
`ifndef MSI_NUM_WIDTH
`define MSI_NUM_WIDTH 11
`endif
`ifndef IRQ_MSG
`define IRQ_MSG 32
`endif
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 64
`endif

module tb_msix_irq_scheduler;
  localparam int N  = 64;
  localparam int VW = 6;
  localparam int MW = `MSI_NUM_WIDTH;
  localparam int AW = `DMA_ADDR_WIDTH;
  localparam int DW = `IRQ_MSG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] tx_irq_req_msix = '0, rx_irq_req_msix = '0;
  logic          tx_irq_req_valid = 1'b0, rx_irq_req_valid = 1'b0;
  logic          tx_irq_req_ready, rx_irq_req_ready;
  logic [N-1:0]  vec_mask = '0;
  logic          func_mask = 1'b0;
  logic [VW-1:0] lut_req_msix;
  logic          lut_req_valid;
  logic          lut_req_ready = 1'b1;
  logic [DW-1:0] lut_rsp_msg = '0;
  logic [AW-1:0] lut_rsp_addr = '0;
  logic          lut_rsp_valid = 1'b0;
  logic          lut_rsp_ready;
  logic [AW-1:0] dma_wr_addr;
  logic [DW-1:0] dma_wr_data;
  logic          dma_wr_valid;
  logic          dma_wr_ready = 1'b1;
  logic [N-1:0]  pending;
  logic          irq_drop;
  logic [1:0]    dbg_state;
  logic [VW-1:0] dbg_rr_ptr;
`ifdef MSIX_IRQ_STATS_EN
  logic [31:0]   irq_sent_cnt, irq_coalesced_cnt;
`endif

  msix_irq_scheduler dut (
    .clk(clk), .rst(rst),
    .tx_irq_req_msix(tx_irq_req_msix), .tx_irq_req_valid(tx_irq_req_valid),
    .tx_irq_req_ready(tx_irq_req_ready),
    .rx_irq_req_msix(rx_irq_req_msix), .rx_irq_req_valid(rx_irq_req_valid),
    .rx_irq_req_ready(rx_irq_req_ready),
    .vec_mask(vec_mask), .func_mask(func_mask),
    .lut_req_msix(lut_req_msix), .lut_req_valid(lut_req_valid), .lut_req_ready(lut_req_ready),
    .lut_rsp_msg(lut_rsp_msg), .lut_rsp_addr(lut_rsp_addr), .lut_rsp_valid(lut_rsp_valid),
    .lut_rsp_ready(lut_rsp_ready),
    .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data), .dma_wr_valid(dma_wr_valid),
    .dma_wr_ready(dma_wr_ready),
    .pending(pending), .irq_drop(irq_drop), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
`ifdef MSIX_IRQ_STATS_EN
    , .irq_sent_cnt(irq_sent_cnt), .irq_coalesced_cnt(irq_coalesced_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0, n_fail = 0;
  int n_drop = 0, n_lut = 0;
  logic [AW+DW-1:0] exp_q[$];
  bit model_pend[N];
  int model_ptr = 0, exp_drop = 0, exp_sent = 0, exp_coal = 0;
  int rsp_lat = 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // MSI-X table contents: vectors 9 and 40 have a null address.
  function automatic logic [AW-1:0] tbl_addr(input int v);
    if (v == 9 || v == 40) return '0;
    return AW'(64'h1000_0000) | (AW'(v ^ 5) << 12);
  endfunction

  function automatic logic [DW-1:0] tbl_msg(input int v);
    if (v == 5) return DW'(5);
    return DW'(32'hC0DE_0000) | DW'(v);
  endfunction

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = model_pend[i];
    return m;
  endfunction

  // ---------------- MSI-X table responder ----------------
  int            rsp_wait = -1;
  logic [VW-1:0] rsp_vec = '0;
  bit            req_hs = 0, rsp_hs = 0;

  always @(negedge clk) begin
    if (rst) begin
      lut_rsp_valid = 1'b0;
      rsp_wait = -1;
      req_hs = 0;
      rsp_hs = 0;
    end else begin
      if (rsp_hs) lut_rsp_valid = 1'b0;
      if (req_hs) rsp_wait = rsp_lat;
      if (rsp_wait == 0) begin
        lut_rsp_valid = 1'b1;
        lut_rsp_addr  = tbl_addr(int'(rsp_vec));
        lut_rsp_msg   = tbl_msg(int'(rsp_vec));
        rsp_wait = -1;
      end else if (rsp_wait > 0) begin
        rsp_wait--;
      end
      req_hs = lut_req_valid && lut_req_ready;
      if (req_hs) rsp_vec = lut_req_msix;
      rsp_hs = lut_rsp_valid && lut_rsp_ready;
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (irq_drop) n_drop++;
      if (lut_req_valid && lut_req_ready) n_lut++;
      if (dma_wr_valid && dma_wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", dma_wr_valid, 0);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          chk("dma_addr", dma_wr_addr, e[AW+DW-1:DW]);
          chk("dma_data", dma_wr_data, e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_irq_req_valid = 1'b0;
    rx_irq_req_valid = 1'b0;
    vec_mask = '0;
    func_mask = 1'b0;
    lut_req_ready = 1'b1;
    dma_wr_ready = 1'b1;
    tick();
    tick();
    exp_q.delete();
    for (int i = 0; i < N; i++) model_pend[i] = 0;
    model_ptr = 0;
    exp_drop = 0;
    exp_sent = 0;
    exp_coal = 0;
    n_drop = 0;
    n_lut = 0;
    rst = 1'b0;
    tick();
  endtask

  // One request cycle on TX and/or RX, with the model updated from the capture rules.
  task automatic req(input bit tv, input int tvec, input bit rv, input int rvec);
    bit hit;
    tx_irq_req_valid = tv;
    tx_irq_req_msix  = MW'(tvec);
    rx_irq_req_valid = rv;
    rx_irq_req_msix  = MW'(rvec);
    hit = 0;
    if ((tv && tvec >= N) || (rv && rvec >= N)) exp_drop++;
    if (tv && tvec < N && model_pend[tvec]) hit = 1;
    if (rv && rvec < N && model_pend[rvec]) hit = 1;
    if (hit) exp_coal++;
    if (tv && tvec < N) model_pend[tvec] = 1;
    if (rv && rvec < N) model_pend[rvec] = 1;
    tick();
    tx_irq_req_valid = 1'b0;
    rx_irq_req_valid = 1'b0;
  endtask

  // Serve every modelled pending vector in circular order starting at the round-robin pointer.
  task automatic flush_model();
    int base;
    base = model_ptr;
    for (int k = 0; k < N; k++) begin
      int v;
      v = (base + k) % N;
      if (model_pend[v]) begin
        model_pend[v] = 0;
        model_ptr = (v + 1) % N;
        if (tbl_addr(v) == '0) begin
          exp_drop++;
        end else begin
          exp_q.push_back({tbl_addr(v), tbl_msg(v)});
          exp_sent++;
        end
      end
    end
  endtask

  task automatic drain(input bit rnd, input int budget);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && dbg_state == 2'd0 && pending == '0) && c < budget) begin
      if (rnd) begin
        lut_req_ready = ($urandom_range(0, 3) != 0);
        dma_wr_ready  = ($urandom_range(0, 3) != 0);
      end
      tick();
      c++;
    end
    lut_req_ready = 1'b1;
    dma_wr_ready  = 1'b1;
    chk("drain_in_budget", (c < budget), 1);
    tick();
    tick();
  endtask

  task automatic post_checks();
    chk("writes_outstanding", exp_q.size(), 0);
    chk("drop_count", n_drop, exp_drop);
    chk("rr_ptr", dbg_rr_ptr, model_ptr);
    chk("state_idle", dbg_state, 0);
`ifdef MSIX_IRQ_STATS_EN
    chk("sent_cnt", irq_sent_cnt, exp_sent);
    chk("coal_cnt", irq_coalesced_cnt, exp_coal);
`endif
  endtask

  task automatic wait_dma_valid(input int budget);
    int c;
    c = 0;
    while (!dma_wr_valid && c < budget) begin
      tick();
      c++;
    end
    chk("dma_valid_seen", dma_wr_valid, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset values, sampled while reset is held and right after release.
    tick();
    chk("rst_req_ready", tx_irq_req_ready, 0);
    chk("rst_lut_valid", lut_req_valid, 0);
    do_reset();
    chk("rst_tx_ready", tx_irq_req_ready, 1);
    chk("rst_rx_ready", rx_irq_req_ready, 1);
    chk("rst_pending", pending, 0);
    chk("rst_outs", {lut_req_valid, lut_rsp_ready, dma_wr_valid, irq_drop}, 0);
    chk("rst_data", {dma_wr_addr, dma_wr_data, lut_req_msix}, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_rr_ptr", dbg_rr_ptr, 0);

    // Single interrupt on vector 5 with a one-cycle table latency.
    rsp_lat = 1;
    req(1, 5, 0, 0);
    flush_model();
    chk("t1_pend_set", pending[5], 1);
    chk("t1_no_lut_yet", lut_req_valid, 0);
    tick();
    chk("t1_pend_clr", pending[5], 0);
    chk("t1_lut_valid", lut_req_valid, 1);
    chk("t1_lut_msix", lut_req_msix, 5);
    tick();
    chk("t1_rsp_ready", lut_rsp_ready, 1);
    tick();
    chk("t1_dma_not_yet", dma_wr_valid, 0);
    tick();
    chk("t1_dma_valid", dma_wr_valid, 1);
    chk("t1_dma_addr", dma_wr_addr, 64'h1000_0000);
    chk("t1_dma_data", dma_wr_data, 5);
    drain(0, 100);
    post_checks();

    // Coalescing on vector 3 while it is held pending by its mask.
    do_reset();
    rsp_lat = 0;
    vec_mask[3] = 1'b1;
    req(1, 3, 1, 3);
    req(1, 3, 0, 0);
    req(1, 3, 0, 0);
    chk("t2_pend3", pending[3], 1);
    vec_mask[3] = 1'b0;
    flush_model();
    drain(0, 100);
    post_checks();

    // Round-robin order: serve vector 1 to move the pointer to 2, then pend {1,2,7}.
    do_reset();
    req(1, 1, 0, 0);
    flush_model();
    drain(0, 100);
    func_mask = 1'b1;
    req(1, 1, 1, 2);
    req(0, 0, 1, 7);
    chk("t3_pend", pending, model_vec());
    func_mask = 1'b0;
    flush_model();
    drain(0, 200);
    post_checks();

    // Per-vector mask and function mask both hold vector 4.
    vec_mask[4] = 1'b1;
    req(1, 4, 0, 0);
    begin
      int lut0;
      lut0 = n_lut;
      repeat (6) tick();
      chk("t4_vmask_no_lut", n_lut, lut0);
      chk("t4_vmask_pend", pending[4], 1);
      func_mask = 1'b1;
      vec_mask[4] = 1'b0;
      repeat (6) tick();
      chk("t4_fmask_no_lut", n_lut, lut0);
      chk("t4_fmask_pend", pending[4], 1);
    end
    func_mask = 1'b0;
    flush_model();
    drain(0, 100);
    post_checks();

    // Out-of-range vector and null table address.
    req(1, 64, 0, 0);
    chk("t5_drop_pulse", irq_drop, 1);
    chk("t5_no_pend", pending, 0);
    tick();
    chk("t5_drop_end", irq_drop, 0);
    req(0, 0, 1, 100);
    chk("t5_rx_drop", irq_drop, 1);
    req(1, 9, 0, 0);
    flush_model();
    drain(0, 100);
    post_checks();

    // DMA back-pressure: write stays stable while vector 6 arrives and waits.
    dma_wr_ready = 1'b0;
    req(1, 10, 0, 0);
    flush_model();
    wait_dma_valid(50);
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) req(1, 6, 0, 0);
      else tick();
      chk("t6_hold_valid", dma_wr_valid, 1);
      chk("t6_hold_addr", dma_wr_addr, tbl_addr(10));
      chk("t6_hold_data", dma_wr_data, tbl_msg(10));
    end
    chk("t6_pend6", pending[6], 1);
    flush_model();
    dma_wr_ready = 1'b1;
    drain(0, 100);
    post_checks();

    // Reset in the middle of an ISSUE with another vector pending.
    dma_wr_ready = 1'b0;
    req(1, 11, 0, 0);
    flush_model();
    wait_dma_valid(50);
    req(1, 12, 0, 0);
    rst = 1'b1;
    tick();
    chk("t7_rst_dma_valid", dma_wr_valid, 0);
    chk("t7_rst_dma", {dma_wr_addr, dma_wr_data}, 0);
    chk("t7_rst_lut", {lut_req_valid, lut_rsp_ready, lut_req_msix}, 0);
    chk("t7_rst_pend", pending, 0);
    chk("t7_rst_drop", irq_drop, 0);
    chk("t7_rst_state", dbg_state, 0);
    do_reset();
    chk("t7_ready_back", tx_irq_req_ready, 1);

    // Randomized rounds: requests collect under func_mask, then drain with random readies.
    for (int r = 0; r < 8; r++) begin
      int n;
      func_mask = 1'b1;
      rsp_lat = $urandom_range(0, 2);
      n = $urandom_range(4, 20);
      for (int i = 0; i < n; i++) begin
        req(1'($urandom_range(0, 1)), $urandom_range(0, 69),
            1'($urandom_range(0, 1)), $urandom_range(0, 69));
      end
      chk("rnd_pend", pending, model_vec());
      func_mask = 1'b0;
      flush_model();
      drain(1, 3000);
      post_checks();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
